// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point FFT frame sequencer.
package fft4_pkg;

   localparam int unsigned SAMPLE_W  = 16;
   localparam int unsigned FRAME_LEN = 4;

   typedef enum logic [1:0] {
      COLLECT,
      COMPUTE,
      DRAIN
   } state_t;

   // Swaps the two index bits; maps natural bin order to core output order and back.
   function automatic logic [1:0] bitrev2(input logic [1:0] v);
      return {v[0], v[1]};
   endfunction

endpackage

// File: rtl/DIF_FFT_4_point.sv
// 4-point radix-2 DIF FFT core, signed complex, results registered one cycle
// after the inputs. Output order is bit-reversed: y0=X0, y1=X2, y2=X1, y3=X3.
// Arithmetic wraps modulo 2^SAMPLE_W with no scaling.
module DIF_FFT_4_point
   import fft4_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic signed [SAMPLE_W-1:0] x0_re,
   input  logic signed [SAMPLE_W-1:0] x0_im,
   input  logic signed [SAMPLE_W-1:0] x1_re,
   input  logic signed [SAMPLE_W-1:0] x1_im,
   input  logic signed [SAMPLE_W-1:0] x2_re,
   input  logic signed [SAMPLE_W-1:0] x2_im,
   input  logic signed [SAMPLE_W-1:0] x3_re,
   input  logic signed [SAMPLE_W-1:0] x3_im,
   output logic signed [SAMPLE_W-1:0] y0_re,
   output logic signed [SAMPLE_W-1:0] y0_im,
   output logic signed [SAMPLE_W-1:0] y1_re,
   output logic signed [SAMPLE_W-1:0] y1_im,
   output logic signed [SAMPLE_W-1:0] y2_re,
   output logic signed [SAMPLE_W-1:0] y2_im,
   output logic signed [SAMPLE_W-1:0] y3_re,
   output logic signed [SAMPLE_W-1:0] y3_im
);

   logic signed [SAMPLE_W-1:0] a_re, a_im, b_re, b_im;
   logic signed [SAMPLE_W-1:0] c_re, c_im, e_re, e_im;

   // First butterfly stage: sums and differences of the half-frame pairs.
   always_comb begin
      a_re = x0_re + x2_re;
      a_im = x0_im + x2_im;
      b_re = x1_re + x3_re;
      b_im = x1_im + x3_im;
      c_re = x0_re - x2_re;
      c_im = x0_im - x2_im;
      e_re = x1_re - x3_re;
      e_im = x1_im - x3_im;
   end

   // Second stage with the -j twiddle on the odd branch, registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         y0_re <= '0;
         y0_im <= '0;
         y1_re <= '0;
         y1_im <= '0;
         y2_re <= '0;
         y2_im <= '0;
         y3_re <= '0;
         y3_im <= '0;
      end else begin
         y0_re <= a_re + b_re;
         y0_im <= a_im + b_im;
         y1_re <= a_re - b_re;
         y1_im <= a_im - b_im;
         y2_re <= c_re + e_im;
         y2_im <= c_im - e_re;
         y3_re <= c_re - e_im;
         y3_im <= c_im + e_re;
      end
   end

endmodule

// File: rtl/fft4_frame_ctrl.sv
// Frame sequencer for the 4-point DIF FFT core: collects four samples,
// waits one compute cycle, then drains four bins over valid/ready.
// Optional macro FFT4_CTRL_NATURAL_ORDER_EN: drain bins in natural k order
// instead of the core's bit-reversed order.
module fft4_frame_ctrl
   import fft4_pkg::*;
#(
   parameter int unsigned FRAME_CNT_W = 16
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sof,
   input  logic signed [SAMPLE_W-1:0] in_re,
   input  logic signed [SAMPLE_W-1:0] in_im,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [SAMPLE_W-1:0] out_re,
   output logic signed [SAMPLE_W-1:0] out_im,
   output logic [1:0]                 out_idx,
   output logic                       out_last,
   output logic                       busy,
   output logic                       sync_err,
   output logic [FRAME_CNT_W-1:0]     frame_cnt
);

   state_t state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [1:0] d, d_nxt;
   logic [1:0] wr_idx, sel, idx;
   logic       wr_en, resync, frame_done;

   logic signed [SAMPLE_W-1:0] samp_re [FRAME_LEN];
   logic signed [SAMPLE_W-1:0] samp_im [FRAME_LEN];
   logic signed [SAMPLE_W-1:0] y_re [FRAME_LEN];
   logic signed [SAMPLE_W-1:0] y_im [FRAME_LEN];

   DIF_FFT_4_point u_core (
      .clk   (clk),
      .reset (reset),
      .x0_re (samp_re[0]),
      .x0_im (samp_im[0]),
      .x1_re (samp_re[1]),
      .x1_im (samp_im[1]),
      .x2_re (samp_re[2]),
      .x2_im (samp_im[2]),
      .x3_re (samp_re[3]),
      .x3_im (samp_im[3]),
      .y0_re (y_re[0]),
      .y0_im (y_im[0]),
      .y1_re (y_re[1]),
      .y1_im (y_im[1]),
      .y2_re (y_re[2]),
      .y2_im (y_im[2]),
      .y3_re (y_re[3]),
      .y3_im (y_im[3])
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= COLLECT;
      else       state <= state_nxt;
   end

   // Sample counter, drain index, resync pulse and completed-frame counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         d         <= '0;
         sync_err  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         cnt      <= cnt_nxt;
         d        <= d_nxt;
         sync_err <= resync;
         if (frame_done) frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Frame buffer feeding the core; only written while collecting.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < FRAME_LEN; i++) begin
            samp_re[i] <= '0;
            samp_im[i] <= '0;
         end
      end else if (wr_en) begin
         samp_re[wr_idx] <= in_re;
         samp_im[wr_idx] <= in_im;
      end
   end

   // Next-state, handshakes and bin output mux.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      d_nxt      = d;
      wr_en      = 1'b0;
      wr_idx     = cnt;
      resync     = 1'b0;
      frame_done = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_idx    = '0;
      out_re     = '0;
      out_im     = '0;
      busy       = (state != COLLECT) || (cnt != '0);
`ifdef FFT4_CTRL_NATURAL_ORDER_EN
      sel = bitrev2(d);
      idx = d;
`else
      sel = d;
      idx = bitrev2(d);
`endif
      unique case (state)
         COLLECT: begin
            in_ready = !reset;
            if (in_valid && in_ready) begin
               wr_en = 1'b1;
               if (in_sof && (cnt != '0)) begin
                  // Mid-frame start-of-frame: discard the partial frame.
                  wr_idx  = '0;
                  cnt_nxt = 2'd1;
                  resync  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 2'd1;
                  if (cnt == 2'(FRAME_LEN - 1)) state_nxt = COMPUTE;
               end
            end
         end
         COMPUTE: begin
            state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (d == 2'(FRAME_LEN - 1));
            out_idx   = idx;
            out_re    = y_re[sel];
            out_im    = y_im[sel];
            if (out_ready) begin
               if (out_last) begin
                  d_nxt      = '0;
                  cnt_nxt    = '0;
                  state_nxt  = COLLECT;
                  frame_done = 1'b1;
               end else begin
                  d_nxt = d + 2'd1;
               end
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Self-checking bench for fft4_frame_ctrl: table-driven basic frame plus
// directed sequences for backpressure, resync, reset and counter wrap.
// Honours FFT4_CTRL_NATURAL_ORDER_EN for the expected bin order.
`timescale 1ns/1ps
module tb_fft4_frame_ctrl;

   localparam int unsigned FCW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_sof = 1'b0;
   logic out_ready = 1'b0;
   logic signed [15:0] in_re = '0;
   logic signed [15:0] in_im = '0;
   logic in_ready, out_valid, out_last, busy, sync_err;
   logic signed [15:0] out_re, out_im;
   logic [1:0] out_idx;
   logic [FCW-1:0] frame_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // Expected bins in natural k order and the drain order in use.
   int nat_re[4];
   int nat_im[4];
   int ord[4];
   int e_re[4];
   int e_im[4];
   int e_idx[4];

   typedef struct {
      logic v;
      logic sof;
      int   re;
      logic rdy;
      logic x_inr;
      logic x_ov;
      int   x_re;
      int   x_im;
      int   x_idx;
      logic x_last;
      logic x_busy;
   } vec_t;

   vec_t tbl[10];

   always #5 clk = ~clk;

   fft4_frame_ctrl #(.FRAME_CNT_W(FCW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sof    (in_sof),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .sync_err  (sync_err),
      .frame_cnt (frame_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_order();
`ifdef FFT4_CTRL_NATURAL_ORDER_EN
      ord = '{0, 1, 2, 3};
`else
      ord = '{0, 2, 1, 3};
`endif
      for (int i = 0; i < 4; i++) begin
         e_re[i]  = nat_re[ord[i]];
         e_im[i]  = nat_im[ord[i]];
         e_idx[i] = ord[i];
      end
   endtask

   // x = 1,2,3,4 (real) -> X = 10, -2+2j, -2, -2-2j
   task automatic exp_1234();
      nat_re = '{10, -2, -2, -2};
      nat_im = '{0, 2, 0, -2};
      set_order();
   endtask

   // x = 8,5,6,7 (real) -> X = 26, 2+2j, 2, 2-2j
   task automatic exp_8567();
      nat_re = '{26, 2, 2, 2};
      nat_im = '{0, 2, 0, -2};
      set_order();
   endtask

   task automatic send_sample(input int re, input int im, input logic sof, input logic exp_sync);
      in_valid = 1'b1;
      in_sof   = sof;
      in_re    = 16'(re);
      in_im    = 16'(im);
      #1;
      chk("collect_in_ready", in_ready, 1);
      chk("collect_out_valid", out_valid, 0);
      step();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("sync_err", sync_err, exp_sync);
   endtask

   task automatic send_1234();
      send_sample(1, 0, 1'b1, 1'b0);
      send_sample(2, 0, 1'b0, 1'b0);
      send_sample(3, 0, 1'b0, 1'b0);
      send_sample(4, 0, 1'b0, 1'b0);
   endtask

   task automatic compute_cycle();
      in_valid = 1'b0;
      #1;
      chk("compute_in_ready", in_ready, 0);
      chk("compute_out_valid", out_valid, 0);
      chk("compute_busy", busy, 1);
      step();
   endtask

   // Drains one frame; pat bit (c%8) is out_ready in drain cycle c.
   task automatic drain_check(input logic [7:0] pat);
      int e;
      e = 0;
      for (int c = 0; c < 16 && e < 4; c++) begin
         out_ready = pat[c % 8];
         #1;
         chk("drain_valid", out_valid, 1);
         chk("drain_in_ready", in_ready, 0);
         chk("drain_re", out_re, e_re[e]);
         chk("drain_im", out_im, e_im[e]);
         chk("drain_idx", out_idx, e_idx[e]);
         chk("drain_last", out_last, (e == 3) ? 1 : 0);
         if (out_valid && out_ready) e++;
         step();
      end
      out_ready = 1'b0;
      chk("drain_bins_accepted", e, 4);
      chk("post_drain_in_ready", in_ready, 1);
      chk("post_drain_out_valid", out_valid, 0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_im", out_im, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk_reset_vals();
      chk("rst_release_in_ready", in_ready, 1);
   endtask

   task automatic idle_no_output(input int n);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         chk("idle_out_valid", out_valid, 0);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a handshake attempt that must be ignored.
      reset    = 1'b1;
      in_valid = 1'b1;
      in_re    = 16'sd99;
      step();
      step();
      chk("reset_cycle_in_ready", in_ready, 0);
      chk_reset_vals();
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("after_reset_in_ready", in_ready, 1);
      chk("after_reset_busy", busy, 0);

      // Table-driven basic frame 1,2,3,4 with out_ready high.
      exp_1234();
      tbl[0] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++)
         tbl[5 + k] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, e_re[k], e_im[k], e_idx[k], (k == 3), 1'b1};
      tbl[9] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         in_valid  = tbl[i].v;
         in_sof    = tbl[i].sof;
         in_re     = 16'(tbl[i].re);
         in_im     = '0;
         out_ready = tbl[i].rdy;
         #1;
         chk("tbl_in_ready", in_ready, tbl[i].x_inr);
         chk("tbl_out_valid", out_valid, tbl[i].x_ov);
         chk("tbl_out_re", out_re, tbl[i].x_re);
         chk("tbl_out_im", out_im, tbl[i].x_im);
         chk("tbl_out_idx", out_idx, tbl[i].x_idx);
         chk("tbl_out_last", out_last, tbl[i].x_last);
         chk("tbl_busy", busy, tbl[i].x_busy);
         step();
      end
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b0;
      chk("tbl_frame_cnt", frame_cnt, 1);

      // Backpressure: out_ready 1,0,0,1,0,1,1 across the drain.
      send_1234();
      compute_cycle();
      drain_check(8'h69);
      chk("bp_frame_cnt", frame_cnt, 2);

      // Resync: sof on the 3rd sample discards the first two.
      exp_8567();
      send_sample(11, 0, 1'b1, 1'b0);
      send_sample(12, 0, 1'b0, 1'b0);
      send_sample(8, 0, 1'b1, 1'b1);
      chk("resync_busy", busy, 1);
      send_sample(5, 0, 1'b0, 1'b0);
      send_sample(6, 0, 1'b0, 1'b0);
      send_sample(7, 0, 1'b0, 1'b0);
      compute_cycle();
      drain_check(8'hFF);
      chk("resync_frame_cnt", frame_cnt, 3);

      // Reset during COMPUTE.
      exp_1234();
      send_1234();
      #1;
      chk("pre_reset_compute_out_valid", out_valid, 0);
      pulse_reset();
      idle_no_output(4);

      // Reset mid-DRAIN after one bin was accepted.
      send_1234();
      compute_cycle();
      out_ready = 1'b1;
      #1;
      chk("mid_drain_valid", out_valid, 1);
      step();
      out_ready = 1'b0;
      chk("mid_drain_second_bin_re", out_re, e_re[1]);
      pulse_reset();
      idle_no_output(4);

      // Clean frame after the resets.
      send_1234();
      compute_cycle();
      drain_check(8'hFF);
      chk("post_reset_frame_cnt", frame_cnt, 1);

      // 17 back-to-back frames at the 9-cycle minimum period: counter wraps to 1.
      pulse_reset();
      for (int f = 0; f < 17; f++) begin
         send_1234();
         compute_cycle();
         drain_check(8'hFF);
         chk("wrap_frame_cnt", frame_cnt, (f + 1) % 16);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
